// File: rtl/dot_matrix_scan.sv
// Row-scan driver for the 8x8 optotype LED matrix, double-buffered, with per-row blanking.
// Latency: pins are registered and track the live row/phase with no visible lag; a frame accepted shows from the next frame's row 0.
// Backpressure: frame_ready is low while the pending buffer is full; it rises on the frame-boundary swap. Macro DOT_MATRIX_DIM_EN adds brightness gating.
module dot_matrix_scan #(
  parameter int DWELL_CYC = 10000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
`ifdef DOT_MATRIX_DIM_EN
  input  logic [2:0]  brightness,
`endif
  input  logic [63:0] frame_data,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [7:0]  col_pin,
  output logic [7:0]  row_pin,
  output logic [2:0]  row_idx,
  output logic        frame_sync
);

  localparam int CW = (DWELL_CYC > 2) ? $clog2(DWELL_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYC - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  // run_q is clear for the single edge after reset so the first live cycle shows row 0 phase 0
  logic          run_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    row_q, row_d;
  logic [63:0]   disp_q, disp_d;
  logic [63:0]   pend_q, pend_d;
  logic          ready_q, ready_d;
  logic [7:0]    col_q, col_d;
  logic [7:0]    rpin_q, rpin_d;
  logic          sync_q, sync_d;
  logic          swap;
  logic          drv_on;
`ifdef DOT_MATRIX_DIM_EN
  logic [2:0]    bright_q, bright_d;
  logic [31:0]   drv_lim;
`endif

  // Next-state: phase/row advance, handshake/swap, and pin values for the cycle being entered
  always_comb begin
    cnt_d  = cnt_q;
    row_d  = row_q;
    disp_d = disp_q;
    pend_d = pend_q;
    ready_d = ready_q;
    swap   = 1'b0;
    if (run_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        row_d = row_q + 3'd1;
        swap  = (row_q == 3'd7);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Accept needs an empty pending buffer and swap needs a full one, so they never coincide
    if (frame_valid && ready_q) begin
      pend_d  = frame_data;
      ready_d = 1'b0;
    end else if (swap && !ready_q) begin
      disp_d  = pend_q;
      ready_d = 1'b1;
    end

`ifdef DOT_MATRIX_DIM_EN
    bright_d = (cnt_d == '0) ? brightness : bright_q;
    drv_lim  = (({29'd0, bright_d} + 32'd1) * 32'(DWELL_CYC - BLANK_CYC)) / 32'd8;
    drv_on   = (32'(cnt_d) < (32'(BLANK_CYC) + drv_lim));
`else
    drv_on   = 1'b1;
`endif

    sync_d = (cnt_d == '0) && (row_d == 3'd0);
    if (cnt_d < CNT_BLANK) begin
      rpin_d = 8'hFF;
      col_d  = 8'h00;
    end else begin
      rpin_d = ~(8'b1 << row_d);
      col_d  = drv_on ? disp_d[{row_d, 3'b000} +: 8] : 8'h00;
    end
  end

  // State and registered pins; reset discards both buffers and restarts the scan
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      row_q   <= 3'd0;
      disp_q  <= 64'h0;
      pend_q  <= 64'h0;
      ready_q <= 1'b1;
      col_q   <= 8'h00;
      rpin_q  <= 8'hFF;
      sync_q  <= 1'b0;
`ifdef DOT_MATRIX_DIM_EN
      bright_q <= 3'd7;
`endif
    end else begin
      run_q   <= 1'b1;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      col_q   <= col_d;
      rpin_q  <= rpin_d;
      sync_q  <= sync_d;
`ifdef DOT_MATRIX_DIM_EN
      bright_q <= bright_d;
`endif
    end
  end

  assign frame_ready = ready_q;
  assign col_pin     = col_q;
  assign row_pin     = rpin_q;
  assign row_idx     = row_q;
  assign frame_sync  = sync_q;

endmodule

// File: tb/tb_dot_matrix_scan.sv
// Bench for dot_matrix_scan: directed scenarios plus random frames, checked every cycle
// against a model built from absolute cycle count (row = k/DWELL mod 8, phase = k mod DWELL).
// Upstream source holds each offered frame until the model says it was accepted.
module tb_dot_matrix_scan;
  localparam int DW = 20;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic [7:0]  col_pin;
  logic [7:0]  row_pin;
  logic [2:0]  row_idx;
  logic        frame_sync;
`ifdef DOT_MATRIX_DIM_EN
  logic [2:0]  brightness = 3'd7;
`endif

  dot_matrix_scan #(.DWELL_CYC(DW), .BLANK_CYC(BL)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef DOT_MATRIX_DIM_EN
    .brightness  (brightness),
`endif
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .col_pin     (col_pin),
    .row_pin     (row_pin),
    .row_idx     (row_idx),
    .frame_sync  (frame_sync)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          k;          // cycle index since reset release, -1 while in reset
  logic        in_rst;
  logic [63:0] m_disp;
  logic [63:0] m_pend;
  logic        m_full;
  int          m_bri;
  logic [63:0] src[$];     // frames the upstream still has to deliver

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h k=%0d", tag, obs, exp, k);
    end
  endtask

  function automatic int ph_of(input int kk);
    return kk % DW;
  endfunction

  function automatic int row_of(input int kk);
    return (kk / DW) % 8;
  endfunction

  // Compare all pins against the model's view of the current cycle
  task automatic check_pins();
    logic [7:0] e_row, e_col;
    int ph, rw;
    if (in_rst) begin
      check("rst_row_pin", row_pin, 8'hFF);
      check("rst_col_pin", col_pin, 8'h00);
      check("rst_sync", frame_sync, 1'b0);
      check("rst_ready", frame_ready, 1'b1);
      check("rst_row_idx", row_idx, 3'd0);
    end else begin
      ph = ph_of(k);
      rw = row_of(k);
      if (ph < BL) begin
        e_row = 8'hFF;
        e_col = 8'h00;
      end else begin
        e_row = 8'hFF;
        e_row[rw] = 1'b0;
        e_col = m_disp[rw*8 +: 8];
`ifdef DOT_MATRIX_DIM_EN
        if ((ph - BL) >= ((m_bri + 1) * (DW - BL)) / 8) e_col = 8'h00;
`endif
      end
      check("row_pin", row_pin, e_row);
      check("col_pin", col_pin, e_col);
      check("row_idx", row_idx, rw[2:0]);
      check("frame_sync", frame_sync, (k % (8 * DW)) == 0);
      check("frame_ready", frame_ready, !m_full);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, check pins 1ns later
  task automatic tick();
    logic acc, old_full;
    frame_valid = (src.size() > 0);
    frame_data  = frame_valid ? src[0] : {$urandom(), $urandom()};
    @(posedge clk);
    if (rst) begin
      in_rst = 1'b1;
      k = -1;
      m_disp = 64'h0;
      m_pend = 64'h0;
      m_full = 1'b0;
      m_bri = 7;
    end else begin
      in_rst = 1'b0;
      old_full = m_full;
      acc = frame_valid && !m_full;
      k++;
      if (acc) begin
        m_pend = frame_data;
        m_full = 1'b1;
        void'(src.pop_front());
      end
      if (k > 0 && (k % (8 * DW)) == 0 && old_full) begin
        m_disp = m_pend;
        m_full = 1'b0;
      end
`ifdef DOT_MATRIX_DIM_EN
      if (ph_of(k) == 0) m_bri = int'(brightness);
`endif
    end
    #1;
    check_pins();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the model sits at (row, phase); bounded to one frame plus slack
  task automatic run_to(input int r, input int p);
    int guard = 0;
    tick();
    while (!(row_of(k) == r && ph_of(k) == p) && guard < 400) begin
      tick();
      guard++;
    end
    if (guard >= 400) begin
      errors++;
      $display("FAIL run_to observed k=%0d expected row=%0d phase=%0d", k, r, p);
    end
  endtask

  initial begin
    logic [63:0] fa, fb;
    in_rst = 1'b1;
    k = -1;
    m_disp = 64'h0;
    m_pend = 64'h0;
    m_full = 1'b0;
    m_bri = 7;
    frame_valid = 1'b0;
    frame_data = 64'h0;

    // Reset held three cycles, pattern offered before release
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    src.push_back(64'h8142241818244281);
    tick();
    check("first_sync", frame_sync, 1'b1);
    check("accepted_ready_low", frame_ready, 1'b0);

    // Load and display in the next frame
    run_to(0, 10);
    check("f0_still_blank_data", col_pin, 8'h00);
    run_to(0, 10);
    check("row0_col", col_pin, 8'h81);
    check("row0_rowpin", row_pin, 8'hFE);
    run_to(3, 2);
    check("row3_blank_row", row_pin, 8'hFF);
    check("row3_blank_col", col_pin, 8'h00);
    run_to(3, 12);
    check("row3_col", col_pin, 8'h18);
    check("row3_rowpin", row_pin, 8'hF7);

    // Back-to-back frames A then B
    fa = 64'hA5A5_0F0F_F0F0_5A5A;
    fb = 64'h0102_0408_1020_4080;
    src.push_back(fa);
    src.push_back(fb);
    tick();
    check("b2b_ready_low", frame_ready, 1'b0);
    run(3 * 8 * DW);

    // Mid-frame write while row 4 drives
    run_to(4, 6);
    src.push_back(64'hDEAD_BEEF_CAFE_F00D);
    run(2 * 8 * DW);

    // Reset during row 5 drive with pending full
    run_to(3, 0);
    src.push_back(64'h1111_2222_3333_4444);
    run_to(5, 8);
    check("pend_full_before_rst", frame_ready, 1'b0);
    rst = 1'b1;
    src.delete();
    tick();
    check("midrst_rowpin", row_pin, 8'hFF);
    check("midrst_ready", frame_ready, 1'b1);
    rst = 1'b0;
    run_to(0, 10);
    check("post_rst_zero", col_pin, 8'h00);
    run(2 * 8 * DW);

    // Randomised frames with random gaps
    for (int i = 0; i < 25; i++) begin
`ifdef DOT_MATRIX_DIM_EN
      brightness = 3'($urandom_range(0, 7));
`endif
      run($urandom_range(0, 200));
      src.push_back({$urandom(), $urandom()});
    end
    run(3 * 8 * DW);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
